// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C target register block.
//   I2C_BYTE_W    - width of one register / one I2C data byte
//   sched_state_t - which agent owns the single register-file port in a cycle
package i2c_pkg;

    localparam int I2C_BYTE_W = 8;

    typedef enum logic [1:0] {
        SCH_IDLE   = 2'd0,
        SCH_I2C_WR = 2'd1,
        SCH_I2C_RD = 2'd2,
        SCH_HOST   = 2'd3
    } sched_state_t;

endpackage

// File: rtl/i2c_regfile.sv
// i2c_regfile: NUM_REGS x 8-bit register storage with one synchronous port.
//   clock, reset - system clock, asynchronous active-high reset (clears all words)
//   we           - write enable for the word selected by addr
//   re           - read enable; rdata loads mem[addr] at the clock edge
//   addr         - word address
//   wdata        - write data
//   rdata        - registered read data (holds between reads)
// Every word must come out of reset as zero, so storage is one resettable
// register per word rather than a RAM macro.
module i2c_regfile
    import i2c_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [I2C_BYTE_W-1:0] wdata,
    output logic [I2C_BYTE_W-1:0] rdata
);

    logic [I2C_BYTE_W-1:0] mem_word [NUM_REGS];
    logic [I2C_BYTE_W-1:0] rdata_reg;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_word
            logic [I2C_BYTE_W-1:0] word_reg;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    word_reg <= '0;
                end else if (we && (addr == ADDR_W'(gi))) begin
                    word_reg <= wdata;
                end
            end

            assign mem_word[gi] = word_reg;
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem_word[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/i2c_reg_arbiter.sv
// i2c_reg_arbiter: register file of an I2C target, shared between the I2C
// target FSM and a chip-side host port.
//   clock, reset               - system clock, asynchronous active-high reset
//   i2c_ptr_load / i2c_ptr_inc - load pointer from i2c_data / increment (wraps)
//   i2c_data                   - byte from the I2C shift register
//   i2c_we / i2c_rd_req        - queue a write / a read prefetch at the pointer
//   i2c_abort                  - stop condition: drop a pending I2C read
//   i2c_rdata / i2c_rvalid     - prefetched byte and its one-cycle update pulse
//   reg_ptr                    - current I2C register pointer
//   host_valid/write/addr/wdata- host request; host_ready is a combinational grant
//   host_rdata / host_rvalid   - host read data, pulse one cycle after acceptance
//   ro_err / ro_err_clr        - sticky flag for I2C writes to read-only registers
// I2C work always wins the port because SCL cannot be stretched; the host only
// gets cycles in which nothing from the I2C side is pending or arriving.
module i2c_reg_arbiter
    import i2c_pkg::*;
#(
    parameter int                  NUM_REGS = 16,
    parameter int                  ADDR_W   = $clog2(NUM_REGS),
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i2c_ptr_load,
    input  logic                  i2c_ptr_inc,
    input  logic [I2C_BYTE_W-1:0] i2c_data,
    input  logic                  i2c_we,
    input  logic                  i2c_rd_req,
    input  logic                  i2c_abort,
    output logic [I2C_BYTE_W-1:0] i2c_rdata,
    output logic                  i2c_rvalid,
    output logic [ADDR_W-1:0]     reg_ptr,
    input  logic                  host_valid,
    input  logic                  host_write,
    input  logic [ADDR_W-1:0]     host_addr,
    input  logic [I2C_BYTE_W-1:0] host_wdata,
    output logic                  host_ready,
    output logic [I2C_BYTE_W-1:0] host_rdata,
    output logic                  host_rvalid,
    output logic                  ro_err,
    input  logic                  ro_err_clr
);

    // Scheduler: state_next is the access issued this cycle; state_reg is the
    // access issued last cycle, whose read data is now on rf_rdata.
    sched_state_t state_reg, state_next;

    logic [ADDR_W-1:0]     ptr_reg;
    logic                  wr_pend_reg;
    logic [ADDR_W-1:0]     wr_addr_reg;
    logic [I2C_BYTE_W-1:0] wr_data_reg;
    logic                  rd_pend_reg;
    logic [ADDR_W-1:0]     rd_addr_reg;
    logic                  host_rd_reg;
    logic [I2C_BYTE_W-1:0] i2c_rdata_hold_reg;
    logic [I2C_BYTE_W-1:0] host_rdata_hold_reg;
    logic                  ro_err_reg;

    logic                  rf_we;
    logic                  rf_re;
    logic [ADDR_W-1:0]     rf_addr;
    logic [I2C_BYTE_W-1:0] rf_wdata;
    logic [I2C_BYTE_W-1:0] rf_rdata;
    logic                  ro_hit;
    logic                  i2c_strobe;

    i2c_regfile #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_regfile (
        .clock (clock),
        .reset (reset),
        .we    (rf_we),
        .re    (rf_re),
        .addr  (rf_addr),
        .wdata (rf_wdata),
        .rdata (rf_rdata)
    );

    // A strobe arriving this cycle will occupy the port next cycle, so the
    // host is held off now to keep I2C latency fixed.
    assign i2c_strobe = i2c_we | i2c_rd_req;
    assign host_ready = host_valid & ~wr_pend_reg & ~rd_pend_reg & ~i2c_strobe & ~reset;

    always_comb begin
        state_next = SCH_IDLE;
        rf_we      = 1'b0;
        rf_re      = 1'b0;
        rf_addr    = host_addr;
        rf_wdata   = host_wdata;
        ro_hit     = 1'b0;
        if (wr_pend_reg) begin
            state_next = SCH_I2C_WR;
            rf_addr    = wr_addr_reg;
            rf_wdata   = wr_data_reg;
            ro_hit     = RO_MASK[wr_addr_reg];
            rf_we      = ~RO_MASK[wr_addr_reg];
        end else if (rd_pend_reg && !i2c_abort) begin
            // An abort in the very cycle the read would run still drops it.
            state_next = SCH_I2C_RD;
            rf_addr    = rd_addr_reg;
            rf_re      = 1'b1;
        end else if (host_ready) begin
            state_next = SCH_HOST;
            rf_we      = host_write;
            rf_re      = ~host_write;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= SCH_IDLE;
            host_rd_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            host_rd_reg <= host_ready & ~host_write;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_reg             <= '0;
            wr_pend_reg         <= 1'b0;
            wr_addr_reg         <= '0;
            wr_data_reg         <= '0;
            rd_pend_reg         <= 1'b0;
            rd_addr_reg         <= '0;
            i2c_rdata_hold_reg  <= '0;
            host_rdata_hold_reg <= '0;
            ro_err_reg          <= 1'b0;
        end else begin
            if (i2c_ptr_load) begin
                ptr_reg <= i2c_data[ADDR_W-1:0];
            end else if (i2c_ptr_inc) begin
                ptr_reg <= ptr_reg + ADDR_W'(1);
            end

            // Strobes capture the pointer as it was before any load/inc
            // in the same cycle.
            if (i2c_we) begin
                wr_pend_reg <= 1'b1;
                wr_addr_reg <= ptr_reg;
                wr_data_reg <= i2c_data;
            end else if (state_next == SCH_I2C_WR) begin
                wr_pend_reg <= 1'b0;
            end

            if (i2c_rd_req) begin
                rd_pend_reg <= 1'b1;
                rd_addr_reg <= ptr_reg;
            end else if (i2c_abort || (state_next == SCH_I2C_RD)) begin
                rd_pend_reg <= 1'b0;
            end

            if (i2c_rvalid) begin
                i2c_rdata_hold_reg <= rf_rdata;
            end
            if (host_rvalid) begin
                host_rdata_hold_reg <= rf_rdata;
            end

            if (ro_hit) begin
                ro_err_reg <= 1'b1;
            end else if (ro_err_clr) begin
                ro_err_reg <= 1'b0;
            end
        end
    end

    // The register file output is shared; each side keeps its last byte in a
    // hold register and sees fresh data directly in the update cycle.
    assign i2c_rvalid  = (state_reg == SCH_I2C_RD);
    assign host_rvalid = (state_reg == SCH_HOST) & host_rd_reg;
    assign i2c_rdata   = i2c_rvalid  ? rf_rdata : i2c_rdata_hold_reg;
    assign host_rdata  = host_rvalid ? rf_rdata : host_rdata_hold_reg;
    assign reg_ptr     = ptr_reg;
    assign ro_err      = ro_err_reg;

endmodule
